// File: rtl/param_sum_accum.sv
// Sequential multi-operand adder: sums `len` WIDTH-bit operands from a stream and emits one result plus a sticky carry flag.
// Latency: out_valid rises the cycle after the last accepted beat (len+1 cycles from start when there are no gaps; 1 cycle for len=0).
// Backpressure: in_ready is high only in ACCUM; in DONE the result is held until out_ready. Define SUM_SAT_EN to saturate instead of wrap.
module param_sum_accum #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             ovf;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] acc_nxt;
  logic             ovf_nxt;
  logic [LEN_W:0]   cnt_inc;
  logic             last_beat;

  // Next accumulator value for a beat, carry tracking and end-of-job detection.
  always_comb begin
    sum_ext   = {1'b0, acc} + {1'b0, in_data};
    ovf_nxt   = ovf | sum_ext[WIDTH];
`ifdef SUM_SAT_EN
    // Once any carry has been seen the job result is pinned at all-ones.
    acc_nxt   = ovf_nxt ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
`else
    acc_nxt   = sum_ext[WIDTH-1:0];
`endif
    cnt_inc   = {1'b0, cnt} + (LEN_W+1)'(1);
    last_beat = (cnt_inc == {1'b0, len_q});
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            busy <= 1'b1;
            if (len != '0) begin
              len_q    <= len;
              in_ready <= 1'b1;
              state    <= ACCUM;
            end else begin
              // Empty job: result is zero with no carry, presented next cycle.
              len_q     <= '0;
              out_sum   <= '0;
              out_ovf   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc <= acc_nxt;
            ovf <= ovf_nxt;
            cnt <= cnt_inc[LEN_W-1:0];
            if (last_beat) begin
              // Result registers load straight from the final beat's sum.
              out_sum   <= acc_nxt;
              out_ovf   <= ovf_nxt;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here, even in the handshake cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_sum_accum.sv
// Self-checking bench for param_sum_accum (WIDTH=8, LEN_W=8).
// Inputs are driven and outputs sampled on the falling edge; jobs come from a vector table.
// Hand-written sequences cover DONE stalls with ignored starts and an asynchronous mid-job reset.
module tb_param_sum_accum;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]      len;
    logic [3:0][7:0] ops;
    logic [3:0]      gap;
    logic [7:0]      exp_sum;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs[8];
  vec_t v_post;

  param_sum_accum #(.WIDTH(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Run one job from the table: start, beats (with optional gaps), result check, handshake.
  task automatic run_job(input vec_t v, input string tag);
    int n;
    n = int'(v.len);
    @(negedge clk);
    chk({tag, " idle_in_ready"}, 32'(in_ready), 0);
    chk({tag, " idle_busy"}, 32'(busy), 0);
    start = 1'b1;
    len   = v.len;
    @(negedge clk);
    start = 1'b0;
    len   = 8'd0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          chk({tag, " gap_in_ready"}, 32'(in_ready), 1);
          @(negedge clk);
        end
      end
      chk({tag, " accum_in_ready"}, 32'(in_ready), 1);
      chk({tag, " accum_out_valid"}, 32'(out_valid), 0);
      in_valid = 1'b1;
      in_data  = v.ops[k];
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'hA5;
    end
    chk({tag, " out_valid"}, 32'(out_valid), 1);
    chk({tag, " done_in_ready"}, 32'(in_ready), 0);
    chk({tag, " done_busy"}, 32'(busy), 1);
    chk({tag, " out_sum"}, 32'(out_sum), 32'(v.exp_sum));
    chk({tag, " out_ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " after_hs_out_valid"}, 32'(out_valid), 0);
    chk({tag, " after_hs_busy"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;

    vecs[0] = '{len: 8'd2, ops: {8'd0, 8'd0, 8'd9, 8'd5},      gap: 4'd0, exp_sum: 8'd14,  exp_ovf: 1'b0};
    vecs[1] = '{len: 8'd2, ops: {8'd0, 8'd0, 8'd2, 8'd10},     gap: 4'd3, exp_sum: 8'd12,  exp_ovf: 1'b0};
`ifdef SUM_SAT_EN
    vecs[2] = '{len: 8'd3, ops: {8'd0, 8'd10, 8'd100, 8'd200}, gap: 4'd0, exp_sum: 8'd255, exp_ovf: 1'b1};
    vecs[4] = '{len: 8'd4, ops: {8'd3, 8'd0, 8'd1, 8'd255},    gap: 4'd0, exp_sum: 8'd255, exp_ovf: 1'b1};
    vecs[6] = '{len: 8'd2, ops: {8'd0, 8'd0, 8'd128, 8'd128},  gap: 4'd0, exp_sum: 8'd255, exp_ovf: 1'b1};
`else
    vecs[2] = '{len: 8'd3, ops: {8'd0, 8'd10, 8'd100, 8'd200}, gap: 4'd0, exp_sum: 8'd54,  exp_ovf: 1'b1};
    vecs[4] = '{len: 8'd4, ops: {8'd3, 8'd0, 8'd1, 8'd255},    gap: 4'd0, exp_sum: 8'd3,   exp_ovf: 1'b1};
    vecs[6] = '{len: 8'd2, ops: {8'd0, 8'd0, 8'd128, 8'd128},  gap: 4'd0, exp_sum: 8'd0,   exp_ovf: 1'b1};
`endif
    vecs[3] = '{len: 8'd0, ops: {8'd0, 8'd0, 8'd0, 8'd0},      gap: 4'd0, exp_sum: 8'd0,   exp_ovf: 1'b0};
    vecs[5] = '{len: 8'd2, ops: {8'd0, 8'd0, 8'd127, 8'd128},  gap: 4'd0, exp_sum: 8'd255, exp_ovf: 1'b0};
    vecs[7] = '{len: 8'd3, ops: {8'd0, 8'd3, 8'd2, 8'd1},      gap: 4'd1, exp_sum: 8'd6,   exp_ovf: 1'b0};
    v_post  = '{len: 8'd1, ops: {8'd0, 8'd0, 8'd0, 8'd7},      gap: 4'd0, exp_sum: 8'd7,   exp_ovf: 1'b0};

    // Reset state, observed before any clock edge.
    #3;
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_sum", 32'(out_sum), 0);
    chk("rst out_ovf", 32'(out_ovf), 0);
    chk("rst busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
    end

    // DONE stall: result held, start pulses ignored, including in the handshake cycle.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd1;
    @(negedge clk);
    start    = 1'b0;
    len      = 8'd0;
    in_valid = 1'b1;
    in_data  = 8'd77;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
    for (int c = 0; c < 5; c++) begin
      chk("stall out_valid", 32'(out_valid), 1);
      chk("stall out_sum", 32'(out_sum), 77);
      chk("stall in_ready", 32'(in_ready), 0);
      start = (c == 2);
      len   = 8'd3;
      @(negedge clk);
    end
    start     = 1'b1;
    len       = 8'd2;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    len       = 8'd0;
    out_ready = 1'b0;
    chk("stall_hs out_valid", 32'(out_valid), 0);
    chk("stall_hs busy", 32'(busy), 0);
    chk("stall_hs in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("stall_hs start_ignored busy", 32'(busy), 0);
    chk("idle holds out_sum", 32'(out_sum), 77);

    // Asynchronous reset after two beats of a four-operand job.
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    len   = 8'd0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k + 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midjob in_ready", 32'(in_ready), 1);
    chk("midjob busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst in_ready", 32'(in_ready), 0);
    chk("async_rst out_valid", 32'(out_valid), 0);
    chk("async_rst out_sum", 32'(out_sum), 0);
    chk("async_rst out_ovf", 32'(out_ovf), 0);
    chk("async_rst busy", 32'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      chk("in_rst out_valid", 32'(out_valid), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst out_valid", 32'(out_valid), 0);
    run_job(v_post, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_sum_accum.md
Name: param_sum_accum

Overview:
Parametrised sequential multi-operand adder, the successor to the combinational two-operand sum function.
- Accepts a runtime-programmed number of WIDTH-bit operands over a valid/ready input stream.
- Accumulates them and presents one result with an overflow flag on a valid/ready output port.
- Used wherever a stream of values must be summed; the plain two-operand add is the len=2 case.

Parameters:
WIDTH, 8, operand and result width in bits
LEN_W, 8, width of the operand-count field; maximum operands per job = 2^LEN_W - 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle job start; honoured only in IDLE
len  input  LEN_W  number of operands in the job; sampled on an accepted start
in_valid  input  1  in_data holds an operand
in_ready  output  1  block can accept an operand this cycle
in_data  input  WIDTH  operand
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_sum  output  WIDTH  accumulated sum
out_ovf  output  1  sticky flag: a carry out of bit WIDTH-1 occurred during the job
busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset (asynchronous, rst_n=0) forces the following, immediately and regardless of clk:
  - state=IDLE
  - accumulator=0, beat counter=0, latched len=0, ovf=0
  - in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- The FSM has three states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - start=1 with len!=0: latch len, clear accumulator, counter and ovf, go to ACCUM.
  - start=1 with len==0: clear accumulator and ovf, go directly to DONE. Result is 0, ovf=0.
- ACCUM:
  - in_ready=1, busy=1.
  - A beat is a cycle with in_valid && in_ready.
  - On a beat, compute acc + in_data at WIDTH+1 bits. The accumulator takes the low WIDTH bits; ovf |= bit WIDTH. The counter increments.
  - Cycles with in_valid=0 change nothing (gaps allowed).
  - On the beat where counter == len-1, go to DONE.
- DONE:
  - out_valid=1, in_ready=0, busy=1.
  - out_sum and out_ovf are stable until the handshake.
  - On out_ready=1, go to IDLE next cycle; out_valid drops.
- Latency: out_valid is asserted the cycle after the last accepted beat. A job with no gaps takes len+1 cycles from start to out_valid.
- start is ignored outside IDLE, including in the DONE handshake cycle. A new start is accepted no earlier than the cycle after the return to IDLE.
- out_sum/out_ovf hold their last value in IDLE. Consumers qualify them with out_valid.
- Wrap mode (default): sum is modulo 2^WIDTH; ovf records any carry.
- A reset mid-job discards the partial sum. No out_valid is produced for that job.

Optional Feature:
SUM_SAT_EN
- Defined:
  - On the first carry, the accumulator clamps to all-ones (2^WIDTH-1) and stays there for the rest of the job.
  - Further beats are still consumed and counted.
  - ovf=1.
- Undefined: wrap mode as above.
- Handshake, latency and ports are identical in both builds.

Test Plan:
1. WIDTH=8, start len=2, beats 5, 9 -> out_valid 1 cycle after the 2nd beat, out_sum=14, out_ovf=0; out_ready=1 -> IDLE, out_valid=0 next cycle.
2. start len=2, beats 10, 2 with 3 idle in_valid=0 cycles between them -> out_sum=12, out_ovf=0, in_ready stays 1 through the gap.
3. start len=3, beats 200, 100, 10:
   - default build -> out_sum=54, out_ovf=1
   - SUM_SAT_EN build -> out_sum=255, out_ovf=1
4. start len=0 -> out_valid the next cycle, out_sum=0, out_ovf=0, in_ready never asserted.
5. len=1, beat 77, hold out_ready=0 for 5 cycles and pulse start during DONE -> out_sum=77 stable, in_ready=0, start ignored; out_ready=1 -> IDLE.
6. len=4, deassert rst_n after 2 beats (3, 4), mid-cycle -> all outputs 0 immediately, no out_valid. After release, len=1, beat 7 -> out_sum=7, out_ovf=0.
